// File: rtl/exu_dispatch_pkg.sv
// Shared codes and types for the EXU dispatch stage: the group encoding, the
// sub-op encodings for each group, and the one-hot op bus widths.
package exu_dispatch_pkg;

    // Instruction group as delivered by the IDU. Codes 5..7 are reserved.
    typedef enum logic [2:0] {
        GRP_NONE = 3'd0,
        GRP_ALU  = 3'd1,
        GRP_BJP  = 3'd2,
        GRP_MEM  = 3'd3,
        GRP_CSR  = 3'd4,
        GRP_RSV5 = 3'd5,
        GRP_RSV6 = 3'd6,
        GRP_RSV7 = 3'd7
    } exu_grp_e;

    // ALU sub-ops; the value is the bit position on alu_op_o.
    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] ALU_OP_SLL  = 4'd2;
    localparam logic [3:0] ALU_OP_SLT  = 4'd3;
    localparam logic [3:0] ALU_OP_SLTU = 4'd4;
    localparam logic [3:0] ALU_OP_XOR  = 4'd5;
    localparam logic [3:0] ALU_OP_SRL  = 4'd6;
    localparam logic [3:0] ALU_OP_SRA  = 4'd7;
    localparam logic [3:0] ALU_OP_OR   = 4'd8;
    localparam logic [3:0] ALU_OP_AND  = 4'd9;

    // BJP sub-ops; the value is the bit position on bjp_op_o.
    localparam logic [3:0] BJP_OP_BEQ  = 4'd0;
    localparam logic [3:0] BJP_OP_BNE  = 4'd1;
    localparam logic [3:0] BJP_OP_BLT  = 4'd2;
    localparam logic [3:0] BJP_OP_BLTU = 4'd3;
    localparam logic [3:0] BJP_OP_BGE  = 4'd4;
    localparam logic [3:0] BJP_OP_BGEU = 4'd5;
    localparam logic [3:0] BJP_OP_JUMP = 4'd6;

    // CSR sub-ops; the value is the bit position on csr_op_o.
    localparam logic [3:0] CSR_OP_CSRRW = 4'd0;
    localparam logic [3:0] CSR_OP_CSRRS = 4'd1;
    localparam logic [3:0] CSR_OP_CSRRC = 4'd2;

    // MEM has a single legal sub-op (address = op1 + op2).
    localparam logic [3:0] MEM_OP_ADDR = 4'd0;

    // Number of legal sub-ops per group, which is also each op bus width.
    localparam int ALU_OP_N = 10;
    localparam int BJP_OP_N = 7;
    localparam int CSR_OP_N = 3;

    // Full 16-way one-hot of a 4-bit sub-op; callers keep the low bits they
    // need, so out-of-range codes naturally decode to an all-zero bus.
    function automatic logic [15:0] op_onehot16(input logic [3:0] op);
        logic [15:0] oh;
        oh = 16'h0001 << op;
        return oh;
    endfunction

endpackage

// File: rtl/exu_disp_op_dec.sv
// Combinational decode of the held dispatch entry into the group request
// strobes, one-hot op buses and the illegal-entry flag.
module exu_disp_op_dec
    import exu_dispatch_pkg::*;
(
    input  logic                vld_i,
    input  logic [2:0]          grp_i,
    input  logic [3:0]          op_i,
    output logic                req_alu_o,
    output logic                req_bjp_o,
    output logic                req_mem_o,
    output logic                req_csr_o,
    output logic [ALU_OP_N-1:0] alu_op_o,
    output logic [BJP_OP_N-1:0] bjp_op_o,
    output logic [CSR_OP_N-1:0] csr_op_o,
    output logic                illegal_o
);

    logic        illegal_s;
    logic [15:0] op_oh_s;
    exu_grp_e    grp_s;

    assign grp_s   = exu_grp_e'(grp_i);
    assign op_oh_s = op_onehot16(op_i);

    // Classify the entry: reserved/none group or a sub-op outside its group's range.
    always_comb begin
        illegal_s = 1'b1;
        case (grp_s)
            GRP_ALU: illegal_s = (op_i >= 4'd10);
            GRP_BJP: illegal_s = (op_i >= 4'd7);
            GRP_MEM: illegal_s = (op_i != MEM_OP_ADDR);
            GRP_CSR: illegal_s = (op_i >= 4'd3);
            default: illegal_s = 1'b1;
        endcase
    end

    // Drive exactly one request and only the active group's op bus; an idle or
    // illegal entry leaves every request low.
    always_comb begin
        req_alu_o = 1'b0;
        req_bjp_o = 1'b0;
        req_mem_o = 1'b0;
        req_csr_o = 1'b0;
        alu_op_o  = {ALU_OP_N{1'b0}};
        bjp_op_o  = {BJP_OP_N{1'b0}};
        csr_op_o  = {CSR_OP_N{1'b0}};
        illegal_o = vld_i & illegal_s;
        if (vld_i) begin
            case (grp_s)
                GRP_ALU: begin
                    req_alu_o = ~illegal_s;
                    alu_op_o  = op_oh_s[ALU_OP_N-1:0];
                end
                GRP_BJP: begin
                    req_bjp_o = ~illegal_s;
                    bjp_op_o  = op_oh_s[BJP_OP_N-1:0];
                end
                GRP_MEM: begin
                    req_mem_o = ~illegal_s;
                end
                GRP_CSR: begin
                    req_csr_o = ~illegal_s;
                    csr_op_o  = op_oh_s[CSR_OP_N-1:0];
                end
                default: begin
                    req_alu_o = 1'b0;
                end
            endcase
        end else begin
            illegal_o = 1'b0;
        end
    end

endmodule

// File: rtl/exu_dispatch.sv
// EXU issue stage: a single-entry pipeline register between the IDU handshake
// and the EXU request interface, with flush, back-pressure and a retire counter.
module exu_dispatch
    import exu_dispatch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dec_valid_i,
    output logic                dec_ready_o,
    input  logic [2:0]          dec_grp_i,
    input  logic [3:0]          dec_op_i,
    input  logic [XLEN-1:0]     dec_op1_i,
    input  logic [XLEN-1:0]     dec_op2_i,
    input  logic [XLEN-1:0]     dec_jop1_i,
    input  logic [XLEN-1:0]     dec_jop2_i,
    input  logic                exe_ready_i,
    input  logic                flush_i,
    output logic                req_alu_o,
    output logic                req_bjp_o,
    output logic                req_mem_o,
    output logic                req_csr_o,
    output logic [ALU_OP_N-1:0] alu_op_o,
    output logic [BJP_OP_N-1:0] bjp_op_o,
    output logic [CSR_OP_N-1:0] csr_op_o,
    output logic [XLEN-1:0]     op1_o,
    output logic [XLEN-1:0]     op2_o,
    output logic [XLEN-1:0]     jop1_o,
    output logic [XLEN-1:0]     jop2_o,
    output logic                illegal_o,
    output logic [CNT_W-1:0]    retire_cnt_o
);

    logic             vld_q,  vld_d;
    logic [2:0]       grp_q,  grp_d;
    logic [3:0]       op_q,   op_d;
    logic [XLEN-1:0]  op1_q,  op1_d;
    logic [XLEN-1:0]  op2_q,  op2_d;
    logic [XLEN-1:0]  jop1_q, jop1_d;
    logic [XLEN-1:0]  jop2_q, jop2_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    logic accept_s;
    logic retire_s;

    // The slot frees up when empty, when the EXU drains it, or when it is flushed.
    assign dec_ready_o = ~vld_q | exe_ready_i | flush_i;
    assign accept_s    = dec_valid_i & dec_ready_o & ~flush_i;
    assign retire_s    = vld_q & exe_ready_i & ~flush_i;

    // Next-state for the entry: flush empties it, accept (re)loads it, retire alone empties it.
    always_comb begin
        vld_d  = vld_q;
        grp_d  = grp_q;
        op_d   = op_q;
        op1_d  = op1_q;
        op2_d  = op2_q;
        jop1_d = jop1_q;
        jop2_d = jop2_q;
        if (flush_i) begin
            vld_d = 1'b0;
        end else if (accept_s) begin
            vld_d  = 1'b1;
            grp_d  = dec_grp_i;
            op_d   = dec_op_i;
            op1_d  = dec_op1_i;
            op2_d  = dec_op2_i;
            jop1_d = dec_jop1_i;
            jop2_d = dec_jop2_i;
        end else if (retire_s) begin
            vld_d = 1'b0;
        end else begin
            vld_d = vld_q;
        end
    end

    // Retire counter advances once per drained entry and wraps at its width.
    always_comb begin
        cnt_d = cnt_q;
        if (retire_s) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pipeline register and retire counter; operands are not cleared when the
    // entry empties, consumers qualify them with the request strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            grp_q  <= 3'd0;
            op_q   <= 4'd0;
            op1_q  <= {XLEN{1'b0}};
            op2_q  <= {XLEN{1'b0}};
            jop1_q <= {XLEN{1'b0}};
            jop2_q <= {XLEN{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
        end else begin
            vld_q  <= vld_d;
            grp_q  <= grp_d;
            op_q   <= op_d;
            op1_q  <= op1_d;
            op2_q  <= op2_d;
            jop1_q <= jop1_d;
            jop2_q <= jop2_d;
            cnt_q  <= cnt_d;
        end
    end

    assign op1_o        = op1_q;
    assign op2_o        = op2_q;
    assign jop1_o       = jop1_q;
    assign jop2_o       = jop2_q;
    assign retire_cnt_o = cnt_q;

    exu_disp_op_dec u_op_dec (
        .vld_i     (vld_q),
        .grp_i     (grp_q),
        .op_i      (op_q),
        .req_alu_o (req_alu_o),
        .req_bjp_o (req_bjp_o),
        .req_mem_o (req_mem_o),
        .req_csr_o (req_csr_o),
        .alu_op_o  (alu_op_o),
        .bjp_op_o  (bjp_op_o),
        .csr_op_o  (csr_op_o),
        .illegal_o (illegal_o)
    );

endmodule

// File: tb/tb_exu_dispatch.sv
// Directed bench for exu_dispatch. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle after the active edge.
// The retire counter is built narrow so its wrap can be reached quickly.
module tb_exu_dispatch;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             dec_valid_i;
    logic             dec_ready_o;
    logic [2:0]       dec_grp_i;
    logic [3:0]       dec_op_i;
    logic [XLEN-1:0]  dec_op1_i;
    logic [XLEN-1:0]  dec_op2_i;
    logic [XLEN-1:0]  dec_jop1_i;
    logic [XLEN-1:0]  dec_jop2_i;
    logic             exe_ready_i;
    logic             flush_i;
    logic             req_alu_o;
    logic             req_bjp_o;
    logic             req_mem_o;
    logic             req_csr_o;
    logic [9:0]       alu_op_o;
    logic [6:0]       bjp_op_o;
    logic [2:0]       csr_op_o;
    logic [XLEN-1:0]  op1_o;
    logic [XLEN-1:0]  op2_o;
    logic [XLEN-1:0]  jop1_o;
    logic [XLEN-1:0]  jop2_o;
    logic             illegal_o;
    logic [CNT_W-1:0] retire_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    wire [3:0]  req_s = {req_csr_o, req_mem_o, req_bjp_o, req_alu_o};
    wire [19:0] bus_s = {csr_op_o, bjp_op_o, alu_op_o};

    exu_dispatch #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dec_valid_i  (dec_valid_i),
        .dec_ready_o  (dec_ready_o),
        .dec_grp_i    (dec_grp_i),
        .dec_op_i     (dec_op_i),
        .dec_op1_i    (dec_op1_i),
        .dec_op2_i    (dec_op2_i),
        .dec_jop1_i   (dec_jop1_i),
        .dec_jop2_i   (dec_jop2_i),
        .exe_ready_i  (exe_ready_i),
        .flush_i      (flush_i),
        .req_alu_o    (req_alu_o),
        .req_bjp_o    (req_bjp_o),
        .req_mem_o    (req_mem_o),
        .req_csr_o    (req_csr_o),
        .alu_op_o     (alu_op_o),
        .bjp_op_o     (bjp_op_o),
        .csr_op_o     (csr_op_o),
        .op1_o        (op1_o),
        .op2_o        (op2_o),
        .jop1_o       (jop1_o),
        .jop2_o       (jop2_o),
        .illegal_o    (illegal_o),
        .retire_cnt_o (retire_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic v, input logic [2:0] g, input logic [3:0] o,
                         input logic [31:0] a, input logic [31:0] b);
        dec_valid_i = v;
        dec_grp_i   = g;
        dec_op_i    = o;
        dec_op1_i   = a;
        dec_op2_i   = b;
        dec_jop1_i  = a ^ 32'hFFFF_0000;
        dec_jop2_i  = b ^ 32'h0000_FFFF;
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        exe_ready_i = 1'b0;
        flush_i     = 1'b0;
        drive(1'b0, 3'd0, 4'd0, 32'h0, 32'h0);
        #1;
        n_vec++;
        if (dec_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready act=%b exp=1", dec_ready_o); end
        n_vec++;
        if (req_s !== 4'h0) begin n_err++; $display("FAIL reset_req act=%h exp=0", req_s); end
        n_vec++;
        if (bus_s !== 20'h0 || illegal_o !== 1'b0) begin
            n_err++; $display("FAIL reset_bus act=%h ill=%b exp=0", bus_s, illegal_o);
        end
        n_vec++;
        if (retire_cnt_o !== 4'd0 || op1_o !== 32'h0 || jop2_o !== 32'h0) begin
            n_err++; $display("FAIL reset_cnt_opnd act=%0d/%h/%h exp=0", retire_cnt_o, op1_o, jop2_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        exe_ready_i = 1'b1;
        drive(1'b1, 3'd1, 4'd0, 32'h0000_0005, 32'h0000_0007);
        @(negedge clk);
        n_vec++;
        if (req_alu_o !== 1'b1 || alu_op_o !== 10'h001 || op1_o !== 32'h5 || op2_o !== 32'h7) begin
            n_err++; $display("FAIL b2b_add act=%b/%h/%h/%h exp=1/001/5/7", req_alu_o, alu_op_o, op1_o, op2_o);
        end
        n_vec++;
        if (retire_cnt_o !== 4'd0) begin n_err++; $display("FAIL b2b_cnt0 act=%0d exp=0", retire_cnt_o); end
        drive(1'b1, 3'd1, 4'd1, 32'h0000_0009, 32'h0000_0003);
        @(negedge clk);
        n_vec++;
        if (req_alu_o !== 1'b1 || alu_op_o !== 10'h002 || op1_o !== 32'h9) begin
            n_err++; $display("FAIL b2b_sub act=%b/%h/%h exp=1/002/9", req_alu_o, alu_op_o, op1_o);
        end
        n_vec++;
        if (retire_cnt_o !== 4'd1) begin n_err++; $display("FAIL b2b_cnt1 act=%0d exp=1", retire_cnt_o); end
        drive(1'b0, 3'd0, 4'd0, 32'h0, 32'h0);
        @(negedge clk);
        n_vec++;
        if (retire_cnt_o !== 4'd2 || req_alu_o !== 1'b0 || alu_op_o !== 10'h000) begin
            n_err++; $display("FAIL b2b_drain act=%0d/%b/%h exp=2/0/000", retire_cnt_o, req_alu_o, alu_op_o);
        end
        n_vec++;
        if (op1_o !== 32'h9) begin n_err++; $display("FAIL b2b_opnd_hold act=%h exp=9", op1_o); end
    endtask

    task automatic test_stall;
        exe_ready_i = 1'b0;
        drive(1'b1, 3'd2, 4'd1, 32'h1234_5678, 32'h0000_0040);
        @(negedge clk);
        drive(1'b1, 3'd1, 4'd0, 32'hAAAA_AAAA, 32'h5555_5555);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (dec_ready_o !== 1'b0 || req_bjp_o !== 1'b1 || bjp_op_o !== 7'h02 || req_alu_o !== 1'b0) begin
                n_err++; $display("FAIL stall_hold[%0d] act=rdy%b req%b op%h alu%b exp=0/1/02/0",
                                  i, dec_ready_o, req_bjp_o, bjp_op_o, req_alu_o);
            end
            n_vec++;
            if (op1_o !== 32'h1234_5678 || jop1_o !== 32'hEDCB_5678 || jop2_o !== 32'h0000_FFBF) begin
                n_err++; $display("FAIL stall_opnd[%0d] act=%h/%h/%h exp=12345678/edcb5678/0000ffbf",
                                  i, op1_o, jop1_o, jop2_o);
            end
            @(negedge clk);
        end
        n_vec++;
        if (retire_cnt_o !== 4'd2) begin n_err++; $display("FAIL stall_cnt act=%0d exp=2", retire_cnt_o); end
        exe_ready_i = 1'b1;
        #1;
        n_vec++;
        if (dec_ready_o !== 1'b1) begin n_err++; $display("FAIL stall_release_rdy act=%b exp=1", dec_ready_o); end
        @(negedge clk);
        n_vec++;
        if (retire_cnt_o !== 4'd3 || req_alu_o !== 1'b1 || alu_op_o !== 10'h001 || op1_o !== 32'hAAAA_AAAA) begin
            n_err++; $display("FAIL stall_reload act=%0d/%b/%h/%h exp=3/1/001/aaaaaaaa",
                              retire_cnt_o, req_alu_o, alu_op_o, op1_o);
        end
        drive(1'b0, 3'd0, 4'd0, 32'h0, 32'h0);
        @(negedge clk);
        n_vec++;
        if (retire_cnt_o !== 4'd4 || req_s !== 4'h0) begin
            n_err++; $display("FAIL stall_drain act=%0d/%h exp=4/0", retire_cnt_o, req_s);
        end
    endtask

    task automatic test_flush;
        exe_ready_i = 1'b0;
        drive(1'b1, 3'd4, 4'd1, 32'hC5C5_0001, 32'h0000_0300);
        @(negedge clk);
        n_vec++;
        if (req_csr_o !== 1'b1 || csr_op_o !== 3'b010) begin
            n_err++; $display("FAIL flush_pre act=%b/%b exp=1/010", req_csr_o, csr_op_o);
        end
        flush_i     = 1'b1;
        exe_ready_i = 1'b1;
        drive(1'b1, 3'd1, 4'd0, 32'hDEAD_0000, 32'h0000_BEEF);
        #1;
        n_vec++;
        if (dec_ready_o !== 1'b1) begin n_err++; $display("FAIL flush_rdy act=%b exp=1", dec_ready_o); end
        @(negedge clk);
        flush_i = 1'b0;
        drive(1'b0, 3'd0, 4'd0, 32'h0, 32'h0);
        n_vec++;
        if (req_s !== 4'h0 || bus_s !== 20'h0 || illegal_o !== 1'b0) begin
            n_err++; $display("FAIL flush_clear act=req%h bus%h ill%b exp=0/0/0", req_s, bus_s, illegal_o);
        end
        n_vec++;
        if (retire_cnt_o !== 4'd4) begin n_err++; $display("FAIL flush_cnt act=%0d exp=4", retire_cnt_o); end
        n_vec++;
        if (op1_o !== 32'hC5C5_0001) begin n_err++; $display("FAIL flush_drop act=%h exp=c5c50001", op1_o); end
    endtask

    task automatic test_illegal;
        logic [2:0]  vg   [9] = '{3'd1, 3'd6, 3'd3, 3'd3, 3'd4, 3'd2, 3'd2, 3'd0, 3'd1};
        logic [3:0]  vo   [9] = '{4'd12, 4'd0, 4'd1, 4'd0, 4'd2, 4'd6, 4'd7, 4'd0, 4'd9};
        logic        vill [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0]  vreq [9] = '{4'h0, 4'h0, 4'h0, 4'h4, 4'h8, 4'h2, 4'h0, 4'h0, 4'h1};
        logic [19:0] vbus [9] = '{20'h0, 20'h0, 20'h0, 20'h0, {3'b100, 17'h0},
                                  {3'b000, 7'h40, 10'h0}, 20'h0, 20'h0, 20'h00200};
        exe_ready_i = 1'b1;
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, vg[k], vo[k], 32'h100 + k, 32'h200 + k);
            @(negedge clk);
            n_vec++;
            if (illegal_o !== vill[k]) begin
                n_err++; $display("FAIL illegal_flag[%0d] act=%b exp=%b", k, illegal_o, vill[k]);
            end
            n_vec++;
            if (req_s !== vreq[k]) begin
                n_err++; $display("FAIL illegal_req[%0d] act=%h exp=%h", k, req_s, vreq[k]);
            end
            n_vec++;
            if (bus_s !== vbus[k]) begin
                n_err++; $display("FAIL illegal_bus[%0d] act=%h exp=%h", k, bus_s, vbus[k]);
            end
        end
        drive(1'b0, 3'd0, 4'd0, 32'h0, 32'h0);
        @(negedge clk);
        n_vec++;
        if (retire_cnt_o !== 4'd13 || illegal_o !== 1'b0) begin
            n_err++; $display("FAIL illegal_cnt act=%0d/%b exp=13/0", retire_cnt_o, illegal_o);
        end
    endtask

    task automatic test_reset_mid;
        exe_ready_i = 1'b0;
        drive(1'b1, 3'd1, 4'd3, 32'h7777_0000, 32'h0000_7777);
        @(negedge clk);
        n_vec++;
        if (req_alu_o !== 1'b1 || dec_ready_o !== 1'b0 || retire_cnt_o !== 4'd13) begin
            n_err++; $display("FAIL rstmid_pre act=%b/%b/%0d exp=1/0/13", req_alu_o, dec_ready_o, retire_cnt_o);
        end
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if (req_s !== 4'h0 || bus_s !== 20'h0 || dec_ready_o !== 1'b1 || retire_cnt_o !== 4'd0) begin
            n_err++; $display("FAIL rstmid act=req%h bus%h rdy%b cnt%0d exp=0/0/1/0",
                              req_s, bus_s, dec_ready_o, retire_cnt_o);
        end
        drive(1'b0, 3'd0, 4'd0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_wrap;
        exe_ready_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 3'd1, 4'd0, i, 32'h1);
            @(negedge clk);
        end
        n_vec++;
        if (retire_cnt_o !== 4'hF) begin n_err++; $display("FAIL wrap_max act=%0d exp=15", retire_cnt_o); end
        drive(1'b0, 3'd0, 4'd0, 32'h0, 32'h0);
        @(negedge clk);
        n_vec++;
        if (retire_cnt_o !== 4'h0) begin n_err++; $display("FAIL wrap_zero act=%0d exp=0", retire_cnt_o); end
        n_vec++;
        if (op1_o !== 32'd16 || req_alu_o !== 1'b0) begin
            n_err++; $display("FAIL wrap_last act=%h/%b exp=10/0", op1_o, req_alu_o);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_flush();
        test_illegal();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
